task_sequencer: RTL and testbench
=================================

// Module: task_sequencer
// PURPOSE
//  PL-side controller for the PS<->PL task mailbox at SMEM_BASE+0x1_0000. It owns the
//  PL_READY/ENABLED_TASKS/CURRENT_TASK/TV_IN_READY/TV_OUT_READY/STATUS registers.
//  It sequences one task engine per request: PS sets TV_IN_READY -> start the selected
//  engine -> wait for done -> raise TV_OUT_READY. It sits between the AXI-lite
//  register decode and the task engines' start/done ports.
// PARAMETERS
//  NUM_TASKS      15          number of task ids (valid ids 1..NUM_TASKS)
//  ENABLED_MASK   15'h7FFF    bit n-1 set = task n implemented; read via ENABLED_TASKS
//  INIT_CYCLES    16          cycles after reset release before PL_READY asserts
//  TIMEOUT_CYCLES 1_000_000   watchdog limit in RUN (only with TASK_SEQ_TIMEOUT_EN)
// PORTS
//  aclk          in   1      single clock, rising edge
//  aresetn       in   1      asynchronous active-low reset
//  reg_wr_en     in   1      register write strobe
//  reg_wr_addr   in   5      byte offset from 0x1_0000 (0x00..0x14), word aligned
//  reg_wr_data   in   32     write data
//  reg_rd_en     in   1      register read strobe
//  reg_rd_addr   in   5      byte offset from 0x1_0000
//  reg_rd_data   out  32     read data, valid with reg_rd_valid
//  reg_rd_valid  out  1      one-cycle pulse, one cycle after reg_rd_en
//  task_id       out  4      id latched at dispatch, held stable through RUN
//  task_start    out  1      one-cycle start pulse to the engine selected by task_id
//  task_done     in   1      one-cycle completion pulse from the active engine
//  task_abort    out  1      one-cycle abort pulse (timeout only)
//  busy          out  1      high in CHECK/START/RUN
// BEHAVIOUR
//  Registers (offset: access):
//   0x00 PL_READY: RO, bit0
//   0x04 ENABLED_TASKS: RO = ENABLED_MASK
//   0x08 CURRENT_TASK: RW, bits[3:0]
//   0x0C TV_IN_READY: RW, bit0
//   0x10 TV_OUT_READY: RO, bit0
//   0x14 STATUS: RO; [0] err_invalid, [1] err_timeout, [31:16] completed-task count
//   Unmapped reads return 0. Unmapped or RO writes are ignored.
//  Reset: all registers 0; outputs 0; state=INIT. Reset mid-task drops task_start/abort
//   immediately and discards the task; no abort pulse is generated.
//  FSM:
//   INIT: count INIT_CYCLES -> WAIT_IN, PL_READY<=1.
//   WAIT_IN: TV_IN_READY==1 -> CHECK; PL_READY<=0, TV_OUT_READY<=0.
//   CHECK (1 cycle): latch task_id=CURRENT_TASK[3:0].
//    - id==0, id>NUM_TASKS or mask bit clear -> err_invalid<=1 and go to DONE without starting.
//    - else -> START, err_invalid<=0, err_timeout<=0.
//   START (1 cycle): task_start=1 -> RUN.
//   RUN: task_done -> DONE. A task_done in any other state is ignored.
//   DONE (1 cycle): TV_IN_READY<=0, TV_OUT_READY<=1, PL_READY<=1, count++ (only
//    after a real completion), -> WAIT_IN.
//  Latency: TV_IN_READY write to task_start = 3 cycles (reg, CHECK, START).
//   task_done to TV_OUT_READY = 2 cycles.
//  Counter wraps 0xFFFF->0. CURRENT_TASK writes outside WAIT_IN/INIT update the register
//   but do not affect the in-flight task_id.
//  Simultaneous PS write TV_IN_READY=1 and the HW clear in DONE: the PS set wins, so the
//   next WAIT_IN dispatches immediately. Writing 0 to TV_IN_READY in WAIT_IN cancels it.
//  Reads in the same cycle as a write to the same register return the pre-write value.
// CONFIGURATION
//  TASK_SEQ_TIMEOUT_EN defined:
//   - 32-bit watchdog, cleared in START, counts in RUN.
//   - At TIMEOUT_CYCLES without task_done: task_abort pulse, err_timeout<=1, -> DONE
//     with count not incremented.
//  Not defined: no watchdog. RUN waits indefinitely, task_abort is tied 0, STATUS[1] reads 0.
// TESTING
//  1. Reset, idle 16 cycles -> PL_READY reads 1 at cycle 17; ENABLED_TASKS reads 0x7FFF.
//  2. Write CURRENT_TASK=2 and TV_IN_READY=1; done 10 cycles after start -> task_start 3
//     cycles after the write with task_id=2; TV_OUT_READY=1, TV_IN_READY=0, STATUS=0x0001_0000.
//  3. CURRENT_TASK=0 then 9 with ENABLED_MASK=15'h00FF -> no task_start; TV_OUT_READY=1,
//     STATUS[0]=1 both times; next valid task clears STATUS[0].
//  4. Write CURRENT_TASK=5 during RUN of task 3 -> task_id stays 3; next dispatch uses 5.
//  5. Pulse aresetn low mid-RUN -> all outputs 0 immediately; PL_READY returns after
//     INIT_CYCLES; a late task_done is ignored.
//  6. TASK_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, no done -> task_abort at RUN cycle 100,
//     STATUS[1]=1, TV_OUT_READY=1, count unchanged.

Source files
------------

// File: rtl/task_sequencer.sv
// task_sequencer: PL-side controller for the PS<->PL task mailbox. Dispatches one task engine
// per TV_IN_READY request. Define TASK_SEQ_TIMEOUT_EN to add the RUN-state watchdog and abort.
module task_sequencer #(
    parameter int          NUM_TASKS      = 15,
    parameter logic [14:0] ENABLED_MASK   = 15'h7FFF,
    parameter int          INIT_CYCLES    = 16,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        reg_wr_en,
    input  logic [4:0]  reg_wr_addr,
    input  logic [31:0] reg_wr_data,
    input  logic        reg_rd_en,
    input  logic [4:0]  reg_rd_addr,
    output logic [31:0] reg_rd_data,
    output logic        reg_rd_valid,
    output logic [3:0]  task_id,
    output logic        task_start,
    input  logic        task_done,
    output logic        task_abort,
    output logic        busy
);

    localparam logic [4:0] ADDR_PL_READY = 5'h00;
    localparam logic [4:0] ADDR_ENABLED  = 5'h04;
    localparam logic [4:0] ADDR_CURRENT  = 5'h08;
    localparam logic [4:0] ADDR_TV_IN    = 5'h0C;
    localparam logic [4:0] ADDR_TV_OUT   = 5'h10;
    localparam logic [4:0] ADDR_STATUS   = 5'h14;

    localparam int                INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_IN,
        S_CHECK,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [INIT_W-1:0] init_cnt_q;
    logic              pl_ready_q;
    logic [3:0]        current_task_q;
    logic              tv_in_ready_q;
    logic              tv_out_ready_q;
    logic              err_invalid_q;
    logic              err_timeout;
    logic [15:0]       count_q;
    logic              completed_q;
    logic [3:0]        task_id_q;
    logic              task_start_q;
    logic              busy_q;
    logic [31:0]       rd_data_d;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;

    logic wr_current;
    logic wr_tv_in;
    logic id_valid;
    logic unused_wdata;

    assign wr_current   = reg_wr_en && (reg_wr_addr == ADDR_CURRENT);
    assign wr_tv_in     = reg_wr_en && (reg_wr_addr == ADDR_TV_IN);
    assign unused_wdata = ^reg_wr_data[31:4];

`ifdef TASK_SEQ_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_q;
    logic        err_timeout_q;
    logic        task_abort_q;

    assign err_timeout = err_timeout_q;
    assign task_abort  = task_abort_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign err_timeout    = 1'b0;
    assign task_abort     = 1'b0;
`endif

    // Id is checked against both the id range and the implemented-engine mask.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        id_valid = 1'b0;
        if (current_task_q != 4'd0 && 32'(current_task_q) <= 32'(NUM_TASKS)) begin
            id_valid = ENABLED_MASK[current_task_q - 4'd1];
        end
    end

    always_comb begin
        rd_data_d = '0;
        case (reg_rd_addr)
            ADDR_PL_READY: rd_data_d = {31'b0, pl_ready_q};
            ADDR_ENABLED:  rd_data_d = {17'b0, ENABLED_MASK};
            ADDR_CURRENT:  rd_data_d = {28'b0, current_task_q};
            ADDR_TV_IN:    rd_data_d = {31'b0, tv_in_ready_q};
            ADDR_TV_OUT:   rd_data_d = {31'b0, tv_out_ready_q};
            ADDR_STATUS:   rd_data_d = {count_q, 14'b0, err_timeout, err_invalid_q};
            default:       rd_data_d = '0;
        endcase
    end

    // Reads sample the registers before this edge's writes, giving pre-write data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees
            // the pre-edge values of the others, independent of statement order.
            rd_valid_q <= reg_rd_en;
            rd_data_q  <= reg_rd_en ? rd_data_d : '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= S_INIT;
            init_cnt_q     <= '0;
            pl_ready_q     <= 1'b0;
            current_task_q <= '0;
            tv_in_ready_q  <= 1'b0;
            tv_out_ready_q <= 1'b0;
            err_invalid_q  <= 1'b0;
            count_q        <= '0;
            completed_q    <= 1'b0;
            task_id_q      <= '0;
            task_start_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
            wd_q           <= '0;
            err_timeout_q  <= 1'b0;
            task_abort_q   <= 1'b0;
`endif
        end else begin
            task_start_q <= 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
            task_abort_q <= 1'b0;
`endif
            if (wr_current) begin
                current_task_q <= reg_wr_data[3:0];
            end

            case (state_q)
                S_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_q    <= S_WAIT_IN;
                        pl_ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (tv_in_ready_q) begin
                        state_q        <= S_CHECK;
                        pl_ready_q     <= 1'b0;
                        tv_out_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                    end
                end
                S_CHECK: begin
                    task_id_q   <= current_task_q;
                    completed_q <= 1'b0;
                    if (id_valid) begin
                        state_q       <= S_START;
                        task_start_q  <= 1'b1;
                        err_invalid_q <= 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
                        err_timeout_q <= 1'b0;
`endif
                    end else begin
                        state_q       <= S_DONE;
                        err_invalid_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                S_START: begin
                    state_q <= S_RUN;
`ifdef TASK_SEQ_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                S_RUN: begin
                    if (task_done) begin
                        state_q     <= S_DONE;
                        completed_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
`ifdef TASK_SEQ_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        state_q       <= S_DONE;
                        task_abort_q  <= 1'b1;
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_q        <= S_WAIT_IN;
                    tv_in_ready_q  <= 1'b0;
                    tv_out_ready_q <= 1'b1;
                    pl_ready_q     <= 1'b1;
                    if (completed_q) begin
                        count_q <= count_q + 16'd1;
                    end
                end
                default: state_q <= S_INIT;
            endcase

            // Placed after the FSM so a PS set wins over the hardware clear in DONE.
            if (wr_tv_in) begin
                tv_in_ready_q <= reg_wr_data[0];
            end
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;
    assign task_id      = task_id_q;
    assign task_start   = task_start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_task_sequencer.sv
// tb_task_sequencer: directed bench for task_sequencer (mask 0x00FF, 16 init cycles,
// watchdog limit 100 when TASK_SEQ_TIMEOUT_EN is defined).
module tb_task_sequencer;

    localparam logic [4:0] A_PL_READY = 5'h00;
    localparam logic [4:0] A_ENABLED  = 5'h04;
    localparam logic [4:0] A_CURRENT  = 5'h08;
    localparam logic [4:0] A_TV_IN    = 5'h0C;
    localparam logic [4:0] A_TV_OUT   = 5'h10;
    localparam logic [4:0] A_STATUS   = 5'h14;

    logic        aclk;
    logic        aresetn;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;
    logic [3:0]  task_id;
    logic        task_start;
    logic        task_done;
    logic        task_abort;
    logic        busy;

    int total = 0;
    int bad   = 0;

    task_sequencer #(
        .NUM_TASKS      (15),
        .ENABLED_MASK   (15'h00FF),
        .INIT_CYCLES    (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .task_id      (task_id),
        .task_start   (task_start),
        .task_done    (task_done),
        .task_abort   (task_abort),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
        reg_wr_en   = 1'b1;
        reg_wr_addr = addr;
        reg_wr_data = data;
        cyc(1);
        reg_wr_en   = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] addr, output logic [31:0] d, output logic v);
        reg_rd_en   = 1'b1;
        reg_rd_addr = addr;
        cyc(1);
        d           = reg_rd_data;
        v           = reg_rd_valid;
        reg_rd_en   = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < max && !seen) begin
            cyc(1);
            n++;
            if (task_start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        v;
        aresetn = 1'b0;
        cyc(3);
        total++;
        if ({busy, task_start, task_abort, task_id, reg_rd_valid, reg_rd_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b start=%b abort=%b id=%h rv=%b rd=%h want all 0",
                     busy, task_start, task_abort, task_id, reg_rd_valid, reg_rd_data);
        end
        aresetn = 1'b1;
        cyc(15);
        reg_read(A_PL_READY, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL pl_ready_cycle16: got d=%h v=%b want d=0 v=1", d, v);
        end
        reg_read(A_PL_READY, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL pl_ready_cycle17: got %h want 1", d);
        end
        cyc(1);
        total++;
        if (reg_rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_pulse: got %b want 0", reg_rd_valid);
        end
        reg_read(A_ENABLED, d, v);
        total++;
        if (d !== 32'h0000_00FF) begin
            bad++;
            $display("FAIL enabled_tasks: got %h want 000000ff", d);
        end
        reg_read(5'h18, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_read: got %h want 0", d);
        end
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL status_after_reset: got %h want 0", d);
        end
    endtask

    task automatic test_single_task;
        logic [31:0] d;
        logic        v;
        reg_write(A_CURRENT, 32'd2);
        reg_write(A_TV_IN, 32'd1);
        cyc(1);
        total++;
        if (task_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL check_cycle: got start=%b busy=%b want start=0 busy=1", task_start, busy);
        end
        cyc(1);
        total++;
        if (task_start !== 1'b1 || task_id !== 4'd2) begin
            bad++;
            $display("FAIL start_latency: got start=%b id=%h want start=1 id=2", task_start, task_id);
        end
        cyc(1);
        total++;
        if (task_start !== 1'b0) begin
            bad++;
            $display("FAIL start_width: got %b want 0", task_start);
        end
        cyc(9);
        task_done = 1'b1;
        cyc(1);
        task_done = 1'b0;
        total++;
        if (busy !== 1'b0 || task_id !== 4'd2) begin
            bad++;
            $display("FAIL done_busy: got busy=%b id=%h want busy=0 id=2", busy, task_id);
        end
        reg_read(A_TV_OUT, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL tv_out_1cyc: got %h want 0", d);
        end
        reg_read(A_TV_OUT, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL tv_out_2cyc: got %h want 1", d);
        end
        reg_read(A_TV_IN, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL tv_in_cleared: got %h want 0", d);
        end
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0001_0000) begin
            bad++;
            $display("FAIL status_task2: got %h want 00010000", d);
        end
    endtask

    task automatic test_invalid;
        logic [31:0] d;
        logic        v;
        logic [3:0]  ids [3];
        bit          saw;
        int          n;
        ids = '{4'd0, 4'd9, 4'd15};
        for (int i = 0; i < 3; i++) begin
            reg_write(A_CURRENT, {28'b0, ids[i]});
            reg_write(A_TV_IN, 32'd1);
            saw = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cyc(1);
                if (task_start === 1'b1) saw = 1'b1;
            end
            total++;
            if (saw !== 1'b0) begin
                bad++;
                $display("FAIL invalid_no_start id=%0d: got start seen want none", ids[i]);
            end
            reg_read(A_TV_OUT, d, v);
            total++;
            if (d !== 32'h1) begin
                bad++;
                $display("FAIL invalid_tv_out id=%0d: got %h want 1", ids[i], d);
            end
            reg_read(A_STATUS, d, v);
            total++;
            if (d !== 32'h0001_0001) begin
                bad++;
                $display("FAIL invalid_status id=%0d: got %h want 00010001", ids[i], d);
            end
        end
        reg_write(A_CURRENT, 32'd1);
        reg_write(A_TV_IN, 32'd1);
        wait_start(8, n, saw);
        total++;
        if (saw !== 1'b1 || task_id !== 4'd1) begin
            bad++;
            $display("FAIL valid_after_invalid: got seen=%b id=%h want seen=1 id=1", saw, task_id);
        end
        cyc(2);
        task_done = 1'b1;
        cyc(1);
        task_done = 1'b0;
        cyc(1);
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0002_0000) begin
            bad++;
            $display("FAIL err_invalid_cleared: got %h want 00020000", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic        v;
        bit          saw;
        int          n;
        reg_write(A_CURRENT, 32'd3);
        reg_write(A_TV_IN, 32'd1);
        wait_start(8, n, saw);
        total++;
        if (saw !== 1'b1 || task_id !== 4'd3) begin
            bad++;
            $display("FAIL task3_start: got seen=%b id=%h want seen=1 id=3", saw, task_id);
        end
        cyc(2);
        reg_wr_en   = 1'b1;
        reg_wr_addr = A_CURRENT;
        reg_wr_data = 32'd5;
        reg_rd_en   = 1'b1;
        reg_rd_addr = A_CURRENT;
        cyc(1);
        d           = reg_rd_data;
        reg_wr_en   = 1'b0;
        reg_rd_en   = 1'b0;
        total++;
        if (d !== 32'd3) begin
            bad++;
            $display("FAIL read_during_write: got %h want 3", d);
        end
        cyc(2);
        total++;
        if (task_id !== 4'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL id_held_in_run: got id=%h busy=%b want id=3 busy=1", task_id, busy);
        end
        reg_read(A_CURRENT, d, v);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL current_task_rw: got %h want 5", d);
        end
        task_done = 1'b1;
        cyc(1);
        task_done   = 1'b0;
        reg_wr_en   = 1'b1;
        reg_wr_addr = A_TV_IN;
        reg_wr_data = 32'd1;
        cyc(1);
        reg_wr_en   = 1'b0;
        total++;
        if (busy !== 1'b0 || task_start !== 1'b0) begin
            bad++;
            $display("FAIL b2b_wait_in: got busy=%b start=%b want 0 0", busy, task_start);
        end
        cyc(1);
        total++;
        if (busy !== 1'b1 || task_start !== 1'b0) begin
            bad++;
            $display("FAIL b2b_check: got busy=%b start=%b want 1 0", busy, task_start);
        end
        cyc(1);
        total++;
        if (task_start !== 1'b1 || task_id !== 4'd5) begin
            bad++;
            $display("FAIL b2b_start: got start=%b id=%h want start=1 id=5", task_start, task_id);
        end
        cyc(1);
        task_done = 1'b1;
        cyc(1);
        task_done = 1'b0;
        cyc(1);
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0004_0000) begin
            bad++;
            $display("FAIL status_count4: got %h want 00040000", d);
        end
        task_done = 1'b1;
        cyc(1);
        task_done = 1'b0;
        cyc(2);
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0004_0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_done_ignored: got status=%h busy=%b want 00040000 0", d, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        logic        v;
        bit          saw;
        int          n;
        reg_write(A_CURRENT, 32'd4);
        reg_write(A_TV_IN, 32'd1);
        wait_start(8, n, saw);
        cyc(3);
        total++;
        if (saw !== 1'b1 || busy !== 1'b1 || task_id !== 4'd4) begin
            bad++;
            $display("FAIL task4_running: got seen=%b busy=%b id=%h want 1 1 4", saw, busy, task_id);
        end
        aresetn = 1'b0;
        #1;
        total++;
        if ({busy, task_start, task_abort, task_id, reg_rd_valid} !== '0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b start=%b abort=%b id=%h rv=%b want all 0",
                     busy, task_start, task_abort, task_id, reg_rd_valid);
        end
        cyc(2);
        aresetn = 1'b1;
        saw = 1'b0;
        cyc(2);
        task_done = 1'b1;
        cyc(1);
        task_done = 1'b0;
        reg_write(A_TV_IN, 32'd1);
        reg_write(A_TV_IN, 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (task_start === 1'b1) saw = 1'b1;
        end
        reg_read(A_PL_READY, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reinit_cycle16: got %h want 0", d);
        end
        reg_read(A_PL_READY, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL reinit_cycle17: got %h want 1", d);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (task_start === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL cancelled_request: got dispatch seen want none");
        end
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL late_done_ignored: got status=%h want 0", d);
        end
        reg_read(A_CURRENT, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL current_reset: got %h want 0", d);
        end
    endtask

`ifdef TASK_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] d;
        logic        v;
        bit          saw;
        int          n;
        reg_write(A_CURRENT, 32'd1);
        reg_write(A_TV_IN, 32'd1);
        wait_start(8, n, saw);
        total++;
        if (saw !== 1'b1) begin
            bad++;
            $display("FAIL timeout_start: got no start want start");
        end
        saw = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            cyc(1);
            if (task_abort === 1'b1) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_early: got abort_seen=%b busy=%b want 0 1", saw, busy);
        end
        cyc(1);
        total++;
        if (task_abort !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse: got abort=%b busy=%b want 1 0", task_abort, busy);
        end
        cyc(1);
        total++;
        if (task_abort !== 1'b0) begin
            bad++;
            $display("FAIL abort_width: got %b want 0", task_abort);
        end
        reg_read(A_STATUS, d, v);
        total++;
        if (d !== 32'h0000_0002) begin
            bad++;
            $display("FAIL timeout_status: got %h want 00000002", d);
        end
        reg_read(A_TV_OUT, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL timeout_tv_out: got %h want 1", d);
        end
    endtask
`endif

    initial begin
        aresetn     = 1'b0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        reg_rd_en   = 1'b0;
        reg_rd_addr = '0;
        task_done   = 1'b0;
        #1;
        test_reset;
        test_single_task;
        test_invalid;
        test_back_to_back;
        test_reset_mid_run;
`ifdef TASK_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
